// File: rtl/fetch_unit_if.sv
// Fetch-side bus bundle: redirect from execute, instruction-memory handshake,
// and the instruction-queue rear port.
interface fetch_unit_if;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        q_full;
  logic        q_push;
  logic [31:0] q_data;

  modport master (
    input  redirect, redirect_pc, mem_ready, mem_rdata, q_full,
    output mem_req, mem_addr, q_push, q_data
  );

  modport slave (
    output redirect, redirect_pc, mem_ready, mem_rdata, q_full,
    input  mem_req, mem_addr, q_push, q_data
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential fetch over a req/ready memory handshake,
// pushes words into the instruction queue, handles back-pressure and redirects.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus,
  output logic [31:0]  pc
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    DROP
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] drop_addr_q, drop_addr_d;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      hold_q      <= '0;
      drop_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      hold_q      <= hold_d;
      drop_addr_q <= drop_addr_d;
    end
  end

  // NOTE: every signal written below gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    hold_d       = hold_q;
    drop_addr_d  = drop_addr_q;
    bus.mem_req  = 1'b0;
    bus.mem_addr = pc_q;
    bus.q_push   = 1'b0;
    bus.q_data   = '0;

    case (state_q)
      IDLE: begin
        state_d = FETCH;
        if (bus.redirect) pc_d = bus.redirect_pc;
      end

      FETCH: begin
        bus.mem_req = 1'b1;
        if (bus.mem_ready) begin
          if (bus.redirect) begin
            pc_d = bus.redirect_pc;
          end else if (!bus.q_full) begin
            bus.q_push = 1'b1;
            bus.q_data = bus.mem_rdata;
            pc_d       = pc_q + PC_STEP;
          end else begin
            hold_d  = bus.mem_rdata;
            pc_d    = pc_q + PC_STEP;
            state_d = HOLD;
          end
        end else if (bus.redirect) begin
          // Request is already on the bus; keep presenting its address until
          // memory answers, then throw the answer away.
          drop_addr_d = pc_q;
          pc_d        = bus.redirect_pc;
          state_d     = DROP;
        end
      end

      HOLD: begin
        if (bus.redirect) begin
          pc_d    = bus.redirect_pc;
          state_d = FETCH;
        end else if (!bus.q_full) begin
          bus.q_push = 1'b1;
          bus.q_data = hold_q;
          state_d    = FETCH;
        end
      end

      DROP: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = drop_addr_q;
        if (bus.redirect)  pc_d    = bus.redirect_pc;
        if (bus.mem_ready) state_d = FETCH;
      end

      default: state_d = IDLE;
    endcase
  end

  assign pc = pc_q;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage for the simple RISC-V core.
- Sits directly upstream of the 32-bit instruction queue.
- Fetches sequential instruction words from instruction memory through a req/ready handshake and pushes each word into the queue's rear port.
- Honours queue back-pressure (full) and branch/jump redirects from execute, discarding stale in-flight data.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
PC_STEP, 4, byte increment between sequential fetches

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-low reset; rst==0 at a rising edge resets the block
redirect  input  1  one-cycle pulse: discard current/queued fetch, restart at redirect_pc
redirect_pc  input  32  new fetch address, valid when redirect==1
mem_req  output  1  fetch request to instruction memory
mem_addr  output  32  word address of the request, equals pc
mem_ready  input  1  memory response valid this cycle; completes handshake when mem_req==1
mem_rdata  input  32  instruction word, valid when mem_ready==1
q_full  input  1  queue full flag
q_push  output  1  push strobe to queue; never asserted while q_full==1
q_data  output  32  word to queue rear, valid when q_push==1
pc  output  32  address of the current/next fetch

Behaviour:
- Reset (rst==0 at edge): state=IDLE, pc=RESET_PC, hold buffer cleared.
  - Resulting outputs: mem_req=0, q_push=0, q_data=0.
  - Reset takes priority over redirect and over any in-flight handshake; an in-flight request is abandoned silently.
- States:
  - IDLE: mem_req=0. Next cycle goes to FETCH. If redirect==1, pc<=redirect_pc.
  - FETCH: mem_req=1, mem_addr=pc; mem_addr is held stable until mem_ready.
    - mem_ready=0, redirect=0: stay.
    - mem_ready=0, redirect=1: pc<=redirect_pc, go DROP. mem_req stays 1 with the old address until the response arrives.
    - mem_ready=1, redirect=1: discard mem_rdata, q_push=0, pc<=redirect_pc, stay FETCH.
    - mem_ready=1, redirect=0, q_full=0: q_push=1, q_data=mem_rdata (combinational, same cycle), pc<=pc+PC_STEP, stay FETCH. Back-to-back fetches give 1 word/cycle when memory is 0-wait.
    - mem_ready=1, redirect=0, q_full=1: latch mem_rdata into hold buffer, pc<=pc+PC_STEP, go HOLD.
  - HOLD: mem_req=0.
    - q_full=0, redirect=0: q_push=1, q_data=hold buffer, go FETCH.
    - redirect=1: drop buffer, q_push=0, pc<=redirect_pc, go FETCH.
    - q_full=1, redirect=0: stay.
  - DROP: mem_req=1 with mem_addr = the latched stale address (not pc); q_push=0 always.
    - On mem_ready: discard the data, go FETCH.
    - A further redirect in DROP overwrites pc; the latest redirect wins.
- pc arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4 = 0. No alignment checks.
- Latency: an instruction reaches q_data in the same cycle mem_ready is sampled (queue direct path), or 1+ cycles later through HOLD.
- Ordering: words are pushed in strictly increasing pc order between redirects. No word is duplicated or lost.
- Invariant: q_push==1 implies q_full==0.
- Invariant: after a redirect, no word fetched from a pre-redirect address is ever pushed.

Test Plan:
- Reset: hold rst=0 for 2 edges, RESET_PC=0 -> mem_req=0, q_push=0, pc=0. First cycle after release mem_req=0 (IDLE); next cycle mem_req=1, mem_addr=0.
- Streaming: mem_ready=1 constantly, mem_rdata=addr+32'h100, q_full=0 -> q_push every cycle, q_data sequence 0x100, 0x104, 0x108…; pc advances by 4 each cycle.
- Back-pressure: q_full=1 when word at addr 8 returns -> q_push=0, mem_req=0 for 3 cycles. Release q_full -> one push of 0x108, then fetch resumes at addr 12.
- Redirect while waiting: mem_ready=0 at addr 4, redirect=1, redirect_pc=0x40 -> mem_req stays on addr 4. Two cycles later mem_ready=1 with data discarded (q_push=0); next request at addr 0x40, first pushed word 0x140.
- Redirect on response cycle and in HOLD: each case -> stale word never pushed, next mem_addr equals redirect_pc.
- Wrap and reset mid-op: RESET_PC=32'hFFFF_FFF8 -> pushed addresses FFFF_FFF8, FFFF_FFFC, 0. Assert rst=0 mid-FETCH -> next cycle mem_req=0, q_push=0, pc=RESET_PC.
